// File: rtl/decode_pkg.sv
// Shared constants for the MIPS decode stage: widths, instruction field positions, opcodes.
package decode_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int ALU_OP_W     = 4;
  localparam int REG_ADDR_W   = 5;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
endpackage

// File: rtl/decode_stage_reg_file.sv
// 32 x XLEN register file, two async read ports and one write port, with
// write-through bypass so a same-cycle write-back is visible to the reader.
module reg_file
  import decode_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int ZERO_REG = 1,
  parameter int RF_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [REG_ADDR_W-1:0] ra0_i,
  input  logic [REG_ADDR_W-1:0] ra1_i,
  output logic [XLEN-1:0]       rd0_o,
  output logic [XLEN-1:0]       rd1_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] wa_i,
  input  logic [XLEN-1:0]       wd_i
);
  logic [XLEN-1:0] regs_q [32];
  logic            wr_ok;

  assign wr_ok = we_i && ((ZERO_REG == 0) || (wa_i != '0));

  generate
    if (RF_RESET != 0) begin : g_rst
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
          regs_q[wa_i] <= wd_i;
        end
      end
    end else begin : g_norst
      logic unused_rst_n;
      assign unused_rst_n = rst_n_i;
      always_ff @(posedge clk_i) begin
        if (wr_ok) regs_q[wa_i] <= wd_i;
      end
    end
  endgenerate

  // Hard-wired zero takes precedence over the bypass path.
  always_comb begin
    rd0_o = regs_q[ra0_i];
    if ((ZERO_REG != 0) && (ra0_i == '0)) rd0_o = '0;
    else if (wr_ok && (wa_i == ra0_i))    rd0_o = wd_i;
  end

  always_comb begin
    rd1_o = regs_q[ra1_i];
    if ((ZERO_REG != 0) && (ra1_i == '0)) rd1_o = '0;
    else if (wr_ok && (wa_i == ra1_i))    rd1_o = wd_i;
  end
endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: register read with bypass, sign extension, branch target/compare
// and the registered ID/EX boundary with stall and flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int ZERO_REG = 1,
  parameter int RF_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       if_id_pc_plus4,
  input  logic [31:0]           if_id_instr,
  input  logic                  ctrl_reg_we,
  input  logic                  ctrl_alu_src,
  input  logic                  ctrl_reg_dst,
  input  logic                  ctrl_mem_we,
  input  logic                  ctrl_mem_re,
  input  logic                  ctrl_mem_to_reg,
  input  logic [ALU_OP_W-1:0]   ctrl_alu_op,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic [5:0]            opcode,
  output logic [XLEN-1:0]       branch_target,
  output logic                  branch_eq,
  output logic                  id_ex_valid,
  output logic [XLEN-1:0]       id_ex_rs_data,
  output logic [XLEN-1:0]       id_ex_rt_data,
  output logic [XLEN-1:0]       id_ex_imm,
  output logic [REG_ADDR_W-1:0] id_ex_rs,
  output logic [REG_ADDR_W-1:0] id_ex_rt,
  output logic [REG_ADDR_W-1:0] id_ex_rd,
  output logic                  id_ex_reg_we,
  output logic                  id_ex_alu_src,
  output logic                  id_ex_reg_dst,
  output logic                  id_ex_mem_we,
  output logic                  id_ex_mem_re,
  output logic                  id_ex_mem_to_reg,
  output logic [ALU_OP_W-1:0]   id_ex_alu_op
);
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [15:0]           imm16;
  logic [XLEN-1:0]       imm_sext;
  logic [XLEN-1:0]       rs_val, rt_val;

  assign opcode   = if_id_instr[OPC_MSB:OPC_LSB];
  assign rs       = if_id_instr[RS_MSB:RS_LSB];
  assign rt       = if_id_instr[RT_MSB:RT_LSB];
  assign rd       = if_id_instr[RD_MSB:RD_LSB];
  assign imm16    = if_id_instr[IMM_MSB:IMM_LSB];
  assign imm_sext = {{(XLEN-16){imm16[15]}}, imm16};

  reg_file #(.XLEN(XLEN), .ZERO_REG(ZERO_REG), .RF_RESET(RF_RESET)) u_rf (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .ra0_i   (rs),
    .ra1_i   (rt),
    .rd0_o   (rs_val),
    .rd1_o   (rt_val),
    .we_i    (wb_we),
    .wa_i    (wb_addr),
    .wd_i    (wb_data)
  );

  assign branch_target = if_id_pc_plus4 + (imm_sext << 2);
  assign branch_eq     = (rs_val == rt_val);

  // Flush still loads the datapath fields; only the side-effecting bits are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_valid      <= 1'b0;
      id_ex_rs_data    <= '0;
      id_ex_rt_data    <= '0;
      id_ex_imm        <= '0;
      id_ex_rs         <= '0;
      id_ex_rt         <= '0;
      id_ex_rd         <= '0;
      id_ex_reg_we     <= 1'b0;
      id_ex_alu_src    <= 1'b0;
      id_ex_reg_dst    <= 1'b0;
      id_ex_mem_we     <= 1'b0;
      id_ex_mem_re     <= 1'b0;
      id_ex_mem_to_reg <= 1'b0;
      id_ex_alu_op     <= '0;
    end else if (flush || !stall) begin
      id_ex_valid      <= !flush;
      id_ex_rs_data    <= rs_val;
      id_ex_rt_data    <= rt_val;
      id_ex_imm        <= imm_sext;
      id_ex_rs         <= rs;
      id_ex_rt         <= rt;
      id_ex_rd         <= rd;
      id_ex_reg_we     <= ctrl_reg_we && !flush;
      id_ex_alu_src    <= ctrl_alu_src;
      id_ex_reg_dst    <= ctrl_reg_dst;
      id_ex_mem_we     <= ctrl_mem_we && !flush;
      id_ex_mem_re     <= ctrl_mem_re && !flush;
      id_ex_mem_to_reg <= ctrl_mem_to_reg;
      id_ex_alu_op     <= ctrl_alu_op;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit and a 64-bit instance share clock,
// reset, instruction and control; XLEN-wide data paths are driven separately.
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] instr;
  logic c_reg_we, c_alu_src, c_reg_dst, c_mem_we, c_mem_re, c_mem_to_reg;
  logic [3:0] c_alu_op;
  logic wb_we;
  logic [4:0] wb_addr;
  logic stall, flush;

  logic [31:0] pc32, wbd32;
  logic [5:0]  opc32;
  logic [31:0] bt32, rsd32, rtd32, imm32;
  logic        beq32, v32;
  logic [4:0]  rs32, rt32, rd32;
  logic        rwe32, asrc32, rdst32, mwe32, mre32, m2r32;
  logic [3:0]  aop32;

  logic [63:0] pc64, wbd64;
  logic [5:0]  opc64;
  logic [63:0] bt64, rsd64, rtd64, imm64;
  logic        beq64, v64;
  logic [4:0]  rs64, rt64, rd64;
  logic        rwe64, asrc64, rdst64, mwe64, mre64, m2r64;
  logic [3:0]  aop64;

  int n_cmp = 0;
  int n_err = 0;

  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .if_id_pc_plus4(pc32), .if_id_instr(instr),
    .ctrl_reg_we(c_reg_we), .ctrl_alu_src(c_alu_src), .ctrl_reg_dst(c_reg_dst),
    .ctrl_mem_we(c_mem_we), .ctrl_mem_re(c_mem_re), .ctrl_mem_to_reg(c_mem_to_reg),
    .ctrl_alu_op(c_alu_op), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wbd32),
    .stall(stall), .flush(flush), .opcode(opc32), .branch_target(bt32),
    .branch_eq(beq32), .id_ex_valid(v32), .id_ex_rs_data(rsd32),
    .id_ex_rt_data(rtd32), .id_ex_imm(imm32), .id_ex_rs(rs32), .id_ex_rt(rt32),
    .id_ex_rd(rd32), .id_ex_reg_we(rwe32), .id_ex_alu_src(asrc32),
    .id_ex_reg_dst(rdst32), .id_ex_mem_we(mwe32), .id_ex_mem_re(mre32),
    .id_ex_mem_to_reg(m2r32), .id_ex_alu_op(aop32)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .if_id_pc_plus4(pc64), .if_id_instr(instr),
    .ctrl_reg_we(c_reg_we), .ctrl_alu_src(c_alu_src), .ctrl_reg_dst(c_reg_dst),
    .ctrl_mem_we(c_mem_we), .ctrl_mem_re(c_mem_re), .ctrl_mem_to_reg(c_mem_to_reg),
    .ctrl_alu_op(c_alu_op), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wbd64),
    .stall(stall), .flush(flush), .opcode(opc64), .branch_target(bt64),
    .branch_eq(beq64), .id_ex_valid(v64), .id_ex_rs_data(rsd64),
    .id_ex_rt_data(rtd64), .id_ex_imm(imm64), .id_ex_rs(rs64), .id_ex_rt(rt64),
    .id_ex_rd(rd64), .id_ex_reg_we(rwe64), .id_ex_alu_src(asrc64),
    .id_ex_reg_dst(rdst64), .id_ex_mem_we(mwe64), .id_ex_mem_re(mre64),
    .id_ex_mem_to_reg(m2r64), .id_ex_alu_op(aop64)
  );

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (v32 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", v32); end
    n_cmp++; if (rsd32 !== 32'h0 || imm32 !== 32'h0 || aop32 !== 4'h0 || rwe32 !== 1'b0)
      begin n_err++; $display("FAIL reset_fields: rs_data %h imm %h alu_op %h reg_we %b want all 0", rsd32, imm32, aop32, rwe32); end
    n_cmp++; if (v64 !== 1'b0 || rsd64 !== 64'h0) begin n_err++; $display("FAIL reset_64: valid %b rs_data %h want 0", v64, rsd64); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    instr = mk_r(OP_RTYPE, 5'd8, 5'd9, {5'd10, 11'd0});
    c_reg_we = 1'b1; c_alu_op = 4'h2;
    wb_we = 1'b1; wb_addr = 5'd8; wbd32 = 32'h0000_1234;
    #1;
    n_cmp++; if (beq32 !== 1'b0) begin n_err++; $display("FAIL bypass_beq_ne: got %b want 0", beq32); end
    step();
    n_cmp++; if (rsd32 !== 32'h0000_1234) begin n_err++; $display("FAIL bypass_rs_data: got %h want 00001234", rsd32); end
    n_cmp++; if (v32 !== 1'b1 || rs32 !== 5'd8 || rt32 !== 5'd9 || rd32 !== 5'd10)
      begin n_err++; $display("FAIL bypass_fields: valid %b rs %0d rt %0d rd %0d want 1 8 9 10", v32, rs32, rt32, rd32); end
    n_cmp++; if (rwe32 !== 1'b1 || aop32 !== 4'h2) begin n_err++; $display("FAIL bypass_ctrl: reg_we %b alu_op %h want 1 2", rwe32, aop32); end
    // r9 written this cycle via bypass, r8 already stored: equal values
    wb_addr = 5'd9; wbd32 = 32'h0000_1234;
    #1;
    n_cmp++; if (beq32 !== 1'b1) begin n_err++; $display("FAIL bypass_beq_eq: got %b want 1", beq32); end
    step();
    wb_we = 1'b0;
    step();
    n_cmp++; if (rsd32 !== 32'h0000_1234 || rtd32 !== 32'h0000_1234)
      begin n_err++; $display("FAIL stored_read: rs %h rt %h want 00001234 00001234", rsd32, rtd32); end
  endtask

  task automatic test_zero_reg();
    instr = mk_r(OP_RTYPE, 5'd0, 5'd0, 16'h0);
    wb_we = 1'b1; wb_addr = 5'd0; wbd32 = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (beq32 !== 1'b1) begin n_err++; $display("FAIL zero_beq: got %b want 1", beq32); end
    step();
    n_cmp++; if (rsd32 !== 32'h0) begin n_err++; $display("FAIL zero_same_cycle: got %h want 0", rsd32); end
    wb_we = 1'b0;
    instr = mk_r(OP_RTYPE, 5'd0, 5'd8, 16'h0);
    step();
    n_cmp++; if (rsd32 !== 32'h0 || rtd32 !== 32'h0000_1234)
      begin n_err++; $display("FAIL zero_later: rs %h rt %h want 0 00001234", rsd32, rtd32); end
  endtask

  task automatic test_branch_target();
    instr = mk_r(OP_BEQ, 5'd1, 5'd2, 16'hFFFC);
    pc32 = 32'h0000_0100;
    #1;
    n_cmp++; if (bt32 !== 32'h0000_00F0) begin n_err++; $display("FAIL bt_neg: got %h want 000000f0", bt32); end
    n_cmp++; if (opc32 !== 6'h04) begin n_err++; $display("FAIL opcode: got %h want 04", opc32); end
    instr = mk_r(OP_BEQ, 5'd1, 5'd2, 16'h0001);
    pc32 = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (bt32 !== 32'h0000_0000) begin n_err++; $display("FAIL bt_wrap: got %h want 00000000", bt32); end
    step();
  endtask

  task automatic test_stall_flush();
    instr = mk_r(OP_LW, 5'd8, 5'd9, 16'h0010);
    c_reg_we = 1'b1; c_mem_re = 1'b1; c_mem_we = 1'b0; c_alu_op = 4'h5;
    step();
    stall = 1'b1;
    instr = mk_r(OP_SW, 5'd3, 5'd4, 16'h0020);
    c_reg_we = 1'b0; c_mem_re = 1'b0; c_mem_we = 1'b1; c_alu_op = 4'h7;
    step();
    instr = mk_r(OP_ADDI, 5'd5, 5'd6, 16'h0030);
    step();
    n_cmp++; if (v32 !== 1'b1 || rs32 !== 5'd8 || rsd32 !== 32'h0000_1234 || imm32 !== 32'h0000_0010)
      begin n_err++; $display("FAIL stall_hold_data: valid %b rs %0d rs_data %h imm %h want 1 8 00001234 00000010", v32, rs32, rsd32, imm32); end
    n_cmp++; if (rwe32 !== 1'b1 || mre32 !== 1'b1 || mwe32 !== 1'b0 || aop32 !== 4'h5)
      begin n_err++; $display("FAIL stall_hold_ctrl: reg_we %b mem_re %b mem_we %b alu_op %h want 1 1 0 5", rwe32, mre32, mwe32, aop32); end
    flush = 1'b1;
    c_reg_we = 1'b1; c_mem_re = 1'b1; c_mem_we = 1'b1;
    step();
    n_cmp++; if (v32 !== 1'b0 || rwe32 !== 1'b0 || mwe32 !== 1'b0 || mre32 !== 1'b0)
      begin n_err++; $display("FAIL flush_bubble: valid %b reg_we %b mem_we %b mem_re %b want 0 0 0 0", v32, rwe32, mwe32, mre32); end
    flush = 1'b0; stall = 1'b0;
    step();
    n_cmp++; if (v32 !== 1'b1 || mwe32 !== 1'b1 || rs32 !== 5'd5)
      begin n_err++; $display("FAIL resume_load: valid %b mem_we %b rs %0d want 1 1 5", v32, mwe32, rs32); end
    c_reg_we = 1'b0; c_mem_re = 1'b0; c_mem_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    instr = mk_r(OP_RTYPE, 5'd5, 5'd0, 16'h0);
    wb_we = 1'b1; wb_addr = 5'd5; wbd32 = 32'h0000_0055;
    step();
    wb_we = 1'b0;
    #1;
    n_cmp++; if (beq32 !== 1'b0) begin n_err++; $display("FAIL r5_written: beq %b want 0", beq32); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (v32 !== 1'b0 || rsd32 !== 32'h0 || rs32 !== 5'd0)
      begin n_err++; $display("FAIL async_reset: valid %b rs_data %h rs %0d want 0 0 0", v32, rsd32, rs32); end
    step();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (beq32 !== 1'b1) begin n_err++; $display("FAIL rf_cleared_comb: beq %b want 1", beq32); end
    step();
    n_cmp++; if (v32 !== 1'b1 || rsd32 !== 32'h0)
      begin n_err++; $display("FAIL rf_cleared: valid %b r5 %h want 1 0", v32, rsd32); end
  endtask

  task automatic test_xlen64();
    instr = mk_r(OP_ADDI, 5'd3, 5'd0, 16'h8000);
    pc64 = 64'h0000_0000_0000_1000;
    wb_we = 1'b1; wb_addr = 5'd3; wbd64 = 64'h0000_0001_0000_0000; wbd32 = 32'h0;
    #1;
    n_cmp++; if (bt64 !== 64'hFFFF_FFFF_FFFE_1000) begin n_err++; $display("FAIL bt64: got %h want fffffffffffe1000", bt64); end
    step();
    n_cmp++; if (imm64 !== 64'hFFFF_FFFF_FFFF_8000) begin n_err++; $display("FAIL imm64: got %h want ffffffffffff8000", imm64); end
    n_cmp++; if (rsd64 !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL bypass64: got %h want 0000000100000000", rsd64); end
    wb_we = 1'b0;
    step();
    n_cmp++; if (rsd64 !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL stored64: got %h want 0000000100000000", rsd64); end
    n_cmp++; if (imm32 !== 32'hFFFF_8000) begin n_err++; $display("FAIL imm32: got %h want ffff8000", imm32); end
  endtask

  initial begin
    instr = 32'h0; pc32 = 32'h0; pc64 = 64'h0; wbd32 = 32'h0; wbd64 = 64'h0;
    c_reg_we = 1'b0; c_alu_src = 1'b0; c_reg_dst = 1'b0; c_mem_we = 1'b0;
    c_mem_re = 1'b0; c_mem_to_reg = 1'b0; c_alu_op = 4'h0;
    wb_we = 1'b0; wb_addr = 5'd0; stall = 1'b0; flush = 1'b0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_branch_target();
    test_stall_flush();
    test_reset_mid();
    test_xlen64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
